gpio_arb: RTL and testbench
===========================

GPIO_ARB -- requirements
Module: gpio_arb

Interface
REQ-001 Parameter TIMEOUT, default 15: slave-ack wait limit in cycles (range 2..255).
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Ports m0_req_i, m1_req_i  input  1 each  master access requests.
REQ-005 Ports m0_we_i, m1_we_i  input  1 each  write enables (1 = write).
REQ-006 Ports m0_addr_i, m1_addr_i, m0_data_i, m1_data_i  input  32 each  master address and write data.
REQ-007 Ports m0_data_o, m1_data_o  output  32 each  registered read data.
REQ-008 Ports m0_ack_o, m1_ack_o, m0_err_o, m1_err_o  output  1 each  completion pulse and timeout flag.
REQ-009 Ports s_req_o, s_we_o  output  1 each; s_addr_o, s_data_o  output  32 each  slave request, enable, address and write data.
REQ-010 Ports s_data_i  input  32, s_ack_i  input  1  slave read data and ack.

Function
REQ-011 FSM states SHALL be IDLE, BUSY0 and BUSY1; reset state is IDLE.
REQ-012 A 1-bit last-grant pointer SHALL exist; reset value 1 (master 0 preferred).
REQ-013 IDLE, only m0_req_i high -> BUSY0; only m1_req_i high -> BUSY1.
REQ-014 IDLE, both requests high -> grant the master not equal to the pointer (round-robin).
REQ-015 IDLE, no grant SHALL occur in a cycle where any m*_ack_o is high; the acked master uses that cycle to drop its request.
REQ-016 BUSYx: s_req_o=1; s_we_o, s_addr_o, s_data_o SHALL combinationally follow master x; pointer<=x on entry.
REQ-017 Outside BUSYx: s_req_o, s_we_o, s_addr_o, s_data_o SHALL be 0.
REQ-018 Masters SHALL hold req, we, addr and data stable from assertion until their ack.
REQ-019 BUSYx with s_ack_i=1 at an edge -> mx_ack_o<=1 for exactly one cycle, mx_data_o<=s_data_i, mx_err_o<=0, state<=IDLE.
REQ-020 Wait counter (8-bit) SHALL clear on entering BUSYx and increment each BUSYx cycle without s_ack_i.
REQ-021 Counter reaching TIMEOUT-1 without s_ack_i -> mx_ack_o<=1 and mx_err_o<=1 for one cycle, mx_data_o<=0, state<=IDLE.
REQ-022 s_ack_i and the timeout condition in the same cycle -> normal ack wins; err stays 0.
REQ-023 mx_req_i dropped in BUSYx before ack -> abort to IDLE next edge; no ack, no err; pointer keeps x.
REQ-024 s_ack_i in IDLE SHALL be ignored.
REQ-025 mx_data_o SHALL hold its value until the next ack to master x.
REQ-026 Latency: req sampled at edge N -> s_req_o high after N; slave ack at edge N+k -> master ack high for the cycle after N+k; minimum 2 cycles req-to-ack.
REQ-027 Write transactions SHALL return slave data on the data output unchanged; the master ignores it.

Reset
REQ-028 rst low SHALL immediately, asynchronously force IDLE, pointer=1, counter=0, all m*_ack_o, m*_err_o = 0 and m*_data_o = 32'h0.
REQ-029 Reset mid-transaction SHALL drop s_req_o at once; the interrupted master receives no ack.
REQ-030 After rst rises, the first rising edge SHALL evaluate IDLE arbitration normally.

Verification
REQ-031 Read: m0 read addr 0x4, slave acks one cycle later with 0x000000A5 -> m0_ack_o one-cycle pulse, m0_data_o=0x000000A5, m0_err_o=0.
REQ-032 Contention: both masters request from reset -> m0 served first, then m1; both requests held continuously -> grants alternate 0,1,0,1.
REQ-033 Timeout: TIMEOUT=15, slave never acks -> m1_ack_o and m1_err_o high together exactly 15 cycles after entering BUSY1, m1_data_o=0.
REQ-034 Race: s_ack_i coincides with the cycle the counter hits TIMEOUT-1 -> ack with err=0 and captured slave data.
REQ-035 Abort/reset: m0 drops req in BUSY0 -> IDLE, no ack; separately, rst low mid-BUSY1 -> s_req_o=0 with no clock edge, all outputs 0.

Source files
------------

// File: rtl/gpio_arb.sv
// gpio_arb: two-master round-robin arbiter in front of a single slave port.
// A granted master owns the slave until the slave acks, the wait limit
// expires (ack + err), or the master withdraws its request (silent abort).
module gpio_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m0_data_o,
  output logic [31:0] m1_data_o,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       ptr, ptr_nxt;
  logic [7:0] cnt;
  logic       busy, cur_req, done_ok, done_to;

  // Completion qualifiers for whichever master currently owns the slave
  always_comb begin
    busy    = (state != IDLE);
    cur_req = (state == BUSY1) ? m1_req_i : m0_req_i;
    done_ok = busy && cur_req && s_ack_i;
    done_to = busy && cur_req && !s_ack_i && (cnt == TO_LAST);
  end

  // Next-state and round-robin pointer update
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        // hold off one cycle after an ack so the served master can drop req
        if (!(m0_ack_o || m1_ack_o)) begin
          if (m0_req_i && (!m1_req_i || ptr)) begin
            state_nxt = BUSY0;
            ptr_nxt   = 1'b0;
          end else if (m1_req_i) begin
            state_nxt = BUSY1;
            ptr_nxt   = 1'b1;
          end
        end
      end
      BUSY0, BUSY1: begin
        if (!cur_req || done_ok || done_to) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= 1'b1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Wait counter, completion pulses and captured read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      m0_ack_o  <= 1'b0;
      m1_ack_o  <= 1'b0;
      m0_err_o  <= 1'b0;
      m1_err_o  <= 1'b0;
      m0_data_o <= '0;
      m1_data_o <= '0;
    end else begin
      if (state == IDLE || state_nxt == IDLE) cnt <= '0;
      else                                    cnt <= cnt + 8'd1;
      m0_ack_o <= (state == BUSY0) && (done_ok || done_to);
      m1_ack_o <= (state == BUSY1) && (done_ok || done_to);
      m0_err_o <= (state == BUSY0) && done_to;
      m1_err_o <= (state == BUSY1) && done_to;
      if (state == BUSY0 && (done_ok || done_to)) m0_data_o <= done_ok ? s_data_i : '0;
      if (state == BUSY1 && (done_ok || done_to)) m1_data_o <= done_ok ? s_data_i : '0;
    end
  end

  // Slave-side mux: follows the owning master, zero otherwise
  always_comb begin
    s_req_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    case (state)
      BUSY0: begin
        s_req_o  = 1'b1;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
      end
      BUSY1: begin
        s_req_o  = 1'b1;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpio_arb.sv
// Directed testbench for gpio_arb.
module tb_gpio_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_data_i, m1_data_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;

  int unsigned total = 0;
  int unsigned passed = 0;

  gpio_arb #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
    .m0_data_i(m0_data_i), .m1_data_i(m1_data_i),
    .m0_data_o(m0_data_o), .m1_data_o(m1_data_o),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
    .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
    m0_addr_i = '0; m1_addr_i = '0; m0_data_i = '0; m1_data_i = '0;
    s_data_i = '0; s_ack_i = 0;
    #2;
    total++; if (s_req_o !== 1'b0) $display("FAIL reset_s_req: got %b expected 0", s_req_o); else passed++;
    total++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); else passed++;
    total++; if ({m0_data_o, m1_data_o} !== 64'h0) $display("FAIL reset_data: got %h expected 0", {m0_data_o, m1_data_o}); else passed++;
    step();
    rst = 1'b1;
  endtask

  task automatic test_read();
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h4;
    step();
    total++; if ({s_req_o, s_we_o} !== 2'b10) $display("FAIL read_s_req_we: got %b expected 10", {s_req_o, s_we_o}); else passed++;
    total++; if (s_addr_o !== 32'h4) $display("FAIL read_s_addr: got %h expected 00000004", s_addr_o); else passed++;
    total++; if (m0_ack_o !== 1'b0) $display("FAIL read_early_ack: got %b expected 0", m0_ack_o); else passed++;
    s_ack_i = 1; s_data_i = 32'h000000A5;
    step();
    total++; if ({m0_ack_o, m0_err_o} !== 2'b10) $display("FAIL read_ack_err: got %b expected 10", {m0_ack_o, m0_err_o}); else passed++;
    total++; if (m0_data_o !== 32'h000000A5) $display("FAIL read_data: got %h expected 000000a5", m0_data_o); else passed++;
    total++; if (s_req_o !== 1'b0) $display("FAIL read_s_req_drop: got %b expected 0", s_req_o); else passed++;
    m0_req_i = 0; s_ack_i = 0; s_data_i = 32'h12345678;
    step();
    total++; if (m0_ack_o !== 1'b0) $display("FAIL read_ack_pulse: got %b expected 0", m0_ack_o); else passed++;
    total++; if (m0_data_o !== 32'h000000A5) $display("FAIL read_data_hold: got %h expected 000000a5", m0_data_o); else passed++;
  endtask

  task automatic test_idle_ack_ignored();
    s_ack_i = 1; s_data_i = 32'hFFFFFFFF;
    step(); step();
    total++; if ({m0_ack_o, m1_ack_o, s_req_o} !== 3'b0) $display("FAIL idle_ack: got %b expected 000", {m0_ack_o, m1_ack_o, s_req_o}); else passed++;
    total++; if (m0_data_o !== 32'h000000A5) $display("FAIL idle_ack_data: got %h expected 000000a5", m0_data_o); else passed++;
    s_ack_i = 0;
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
    rst = 0; #2; rst = 1;
    m0_req_i = 1; m0_addr_i = 32'h100; m0_we_i = 1; m0_data_i = 32'hAAAA0000;
    m1_req_i = 1; m1_addr_i = 32'h200; m1_we_i = 0; m1_data_i = 32'hBBBB0000;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (s_addr_o !== exp_addr[i]) $display("FAIL rr_grant%0d: got addr %h expected %h", i, s_addr_o, exp_addr[i]); else passed++;
      s_ack_i = 1; s_data_i = 32'hC0 + i;
      step();
      if (i % 2 == 0) begin
        total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) $display("FAIL rr_ack%0d: got %b expected 10", i, {m0_ack_o, m1_ack_o}); else passed++;
      end else begin
        total++; if ({m0_ack_o, m1_ack_o} !== 2'b01) $display("FAIL rr_ack%0d: got %b expected 01", i, {m0_ack_o, m1_ack_o}); else passed++;
      end
      s_ack_i = 0;
      step();
      total++; if (s_req_o !== 1'b0) $display("FAIL rr_gap%0d: got %b expected 0", i, s_req_o); else passed++;
    end
    total++; if (m0_data_o !== 32'hC2) $display("FAIL rr_m0_data: got %h expected 000000c2", m0_data_o); else passed++;
    total++; if (m1_data_o !== 32'hC3) $display("FAIL rr_m1_data: got %h expected 000000c3", m1_data_o); else passed++;
    m0_req_i = 0; m1_req_i = 0;
    step();
  endtask

  task automatic test_write_passthrough();
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h300; m1_data_i = 32'hCAFEF00D;
    step();
    total++; if ({s_req_o, s_we_o} !== 2'b11) $display("FAIL wr_s_req_we: got %b expected 11", {s_req_o, s_we_o}); else passed++;
    total++; if (s_data_o !== 32'hCAFEF00D) $display("FAIL wr_s_data: got %h expected cafef00d", s_data_o); else passed++;
    s_ack_i = 1; s_data_i = 32'h55AA55AA;
    step();
    total++; if (m1_data_o !== 32'h55AA55AA) $display("FAIL wr_return_data: got %h expected 55aa55aa", m1_data_o); else passed++;
    s_ack_i = 0; m1_req_i = 0; m1_we_i = 0;
    step();
  endtask

  task automatic test_timeout();
    int unsigned early = 0;
    m1_req_i = 1; m1_addr_i = 32'h400;
    step();
    for (int i = 1; i <= 14; i++) begin
      step();
      if (m1_ack_o !== 1'b0 || s_req_o !== 1'b1) early++;
    end
    total++; if (early !== 0) $display("FAIL to_early: got %0d bad cycles expected 0", early); else passed++;
    step();
    total++; if ({m1_ack_o, m1_err_o} !== 2'b11) $display("FAIL to_ack_err: got %b expected 11", {m1_ack_o, m1_err_o}); else passed++;
    total++; if (m1_data_o !== 32'h0) $display("FAIL to_data: got %h expected 00000000", m1_data_o); else passed++;
    m1_req_i = 0;
    step();
    total++; if ({m1_ack_o, m1_err_o} !== 2'b00) $display("FAIL to_pulse: got %b expected 00", {m1_ack_o, m1_err_o}); else passed++;
  endtask

  task automatic test_race();
    int unsigned early = 0;
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h500;
    step();
    for (int i = 1; i <= 14; i++) begin
      step();
      if (m0_ack_o !== 1'b0) early++;
    end
    total++; if (early !== 0) $display("FAIL race_early: got %0d bad cycles expected 0", early); else passed++;
    s_ack_i = 1; s_data_i = 32'hDEADBEEF;
    step();
    total++; if ({m0_ack_o, m0_err_o} !== 2'b10) $display("FAIL race_ack_err: got %b expected 10", {m0_ack_o, m0_err_o}); else passed++;
    total++; if (m0_data_o !== 32'hDEADBEEF) $display("FAIL race_data: got %h expected deadbeef", m0_data_o); else passed++;
    s_ack_i = 0; m0_req_i = 0;
    step();
  endtask

  task automatic test_abort_and_reset();
    m0_req_i = 1; m0_addr_i = 32'h600;
    step();
    total++; if (s_req_o !== 1'b1) $display("FAIL abort_busy: got %b expected 1", s_req_o); else passed++;
    m0_req_i = 0;
    step();
    total++; if ({s_req_o, m0_ack_o, m0_err_o} !== 3'b0) $display("FAIL abort_idle: got %b expected 000", {s_req_o, m0_ack_o, m0_err_o}); else passed++;
    step();
    total++; if (m0_ack_o !== 1'b0) $display("FAIL abort_no_ack: got %b expected 0", m0_ack_o); else passed++;
    // pointer stayed at master 0, so a tie now goes to master 1
    m0_req_i = 1; m1_req_i = 1; m1_addr_i = 32'h700;
    step();
    total++; if (s_addr_o !== 32'h700) $display("FAIL abort_ptr: got %h expected 00000700", s_addr_o); else passed++;
    #2 rst = 0;
    #1;
    total++; if (s_req_o !== 1'b0 || s_addr_o !== 32'h0) $display("FAIL rst_async_s: got %b/%h expected 0/00000000", s_req_o, s_addr_o); else passed++;
    total++; if ({m0_data_o, m1_data_o} !== 64'h0 || {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) $display("FAIL rst_async_m: got %h %b expected 0", {m0_data_o, m1_data_o}, {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); else passed++;
    s_ack_i = 1; s_data_i = 32'h99;
    #3 rst = 1;
    s_ack_i = 0;
    step();
    total++; if (s_addr_o !== 32'h600) $display("FAIL rst_ptr_m0: got %h expected 00000600", s_addr_o); else passed++;
    total++; if (m1_ack_o !== 1'b0) $display("FAIL rst_no_m1_ack: got %b expected 0", m1_ack_o); else passed++;
    m0_req_i = 0; m1_req_i = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_idle_ack_ignored();
    test_contention();
    test_write_passthrough();
    test_timeout();
    test_race();
    test_abort_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
